// File: rtl/priority_arbiter.sv
// priority_arbiter: 4-requester registered arbiter, 3>2>1>0 priority, hold timeout, one-cycle turnaround.
// Define ROUND_ROBIN_EN to rotate priority after every grant.
module priority_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       timeout
);
    localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    prev, prev_n, id_n, win;
    logic [3:0]    grant_n, elig;
    logic          to_n;

`ifdef ROUND_ROBIN_EN
    logic [1:0] p, p_n;

    // Priority runs p, p-1, p-2, p-3; the last hit in this loop is the highest.
    function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] ptr);
        logic [1:0] idx;
        pick = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr - 2'(k);
            if (e[idx]) pick = idx;
        end
    endfunction
`else
    function automatic logic [1:0] pick(input logic [3:0] e);
        pick = 2'd0;
        for (int k = 0; k < 4; k++)
            if (e[k]) pick = 2'(k);
    endfunction
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        prev_n  = prev;
        grant_n = 4'b0;
        id_n    = 2'd0;
        to_n    = 1'b0;
`ifdef ROUND_ROBIN_EN
        p_n     = p;
        win     = pick(elig_of(req, timeout, prev), p);
`else
        win     = pick(elig_of(req, timeout, prev));
`endif
        elig    = elig_of(req, timeout, prev);
        case (state)
            GRANT: begin
                if (req[prev] && !((MAX_HOLD != 0) && (cnt == MAXC))) begin
                    grant_n = grant;
                    id_n    = prev;
                    cnt_n   = &cnt ? cnt : cnt + 1'b1;
                end else begin
                    state_n = RELEASE;
                    to_n    = req[prev];
                end
            end
            default: begin
                if (|elig) begin
                    state_n = GRANT;
                    grant_n = 4'b1 << win;
                    id_n    = win;
                    prev_n  = win;
                    cnt_n   = CW'(1);
`ifdef ROUND_ROBIN_EN
                    p_n     = win - 2'd1;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    // timeout is high only during the turnaround after a revoked grant, so it doubles as the mask flag.
    function automatic logic [3:0] elig_of(input logic [3:0] r, input logic t, input logic [1:0] o);
        elig_of = t ? (r & ~(4'b1 << o)) : r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prev        <= 2'd0;
            grant       <= 4'b0;
            grant_valid <= 1'b0;
            grant_id    <= 2'd0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            prev        <= prev_n;
            grant       <= grant_n;
            grant_valid <= |grant_n;
            grant_id    <= id_n;
            timeout     <= to_n;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) p <= 2'd3;
        else       p <= p_n;
    end
`endif
endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter: vector table plus scoreboard for two arbiters (MAX_HOLD 8 and 4), with reset sequences.
module tb_priority_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req8, req4, g8, g4;
    logic       v8, v4, t8, t4;
    logic [1:0] id8, id4;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    priority_arbiter #(.MAX_HOLD(8)) u8 (
        .clk(clk), .reset(reset), .req(req8), .grant(g8),
        .grant_valid(v8), .grant_id(id8), .timeout(t8)
    );
    priority_arbiter #(.MAX_HOLD(4)) u4 (
        .clk(clk), .reset(reset), .req(req4), .grant(g4),
        .grant_valid(v4), .grant_id(id4), .timeout(t4)
    );

    typedef struct {
        logic [3:0] r8, r4, e8, e4;
        logic       et8, et4;
        int         n;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    logic [3:0] seq[5];

    function automatic logic [1:0] enc(input logic [3:0] g);
        enc = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    endfunction

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] g, input logic v, input logic [1:0] id,
                       input logic t, input logic [3:0] eg, input logic et);
        cmp({nm, " grant"}, g, eg);
        cmp({nm, " valid"}, {3'b0, v}, {3'b0, |eg});
        cmp({nm, " id"}, {2'b0, id}, {2'b0, enc(eg)});
        cmp({nm, " timeout"}, {3'b0, t}, {3'b0, et});
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        req8 = v.r8;
        req4 = v.r4;
        sb.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("mh8", g8, v8, id8, t8, e.e8, e.et8);
        chk("mh4", g4, v4, id4, t4, e.e4, e.et4);
    endtask

    task automatic add(input logic [3:0] r8, input logic [3:0] r4, input logic [3:0] e8,
                       input logic et8, input logic [3:0] e4, input logic et4, input int n);
        tbl.push_back(vec_t'{r8: r8, r4: r4, e8: e8, e4: e4, et8: et8, et4: et4, n: n});
    endtask

    initial begin
`ifdef ROUND_ROBIN_EN
        seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
`else
        seq = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
`endif
        // priority pick, then voluntary release and regrant of the lower requester
        add(4'b0101, 4'b0101, 4'b0100, 0, 4'b0100, 0, 2);
        add(4'b0001, 4'b0001, 4'b0000, 0, 4'b0000, 0, 1);
        add(4'b0001, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1);
        add(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2);
        // lone requester held past MAX_HOLD=8: timeout, masked -> idle, regrant
        for (int k = 0; k < 2; k++) begin
            add(4'b1000, 4'b0000, 4'b1000, 0, 4'b0000, 0, 8);
            add(4'b1000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1);
            add(4'b1000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1);
        end
        add(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1);
        // all requesting with MAX_HOLD=4
        for (int k = 0; k < 5; k++) begin
            add(4'b0000, 4'b1111, 4'b0000, 0, seq[k], 0, 4);
            add(4'b0000, 4'b1111, 4'b0000, 0, 4'b0000, 1, 1);
        end
        add(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1);
        // owner drops on the same edge its count reaches MAX_HOLD: voluntary, no timeout
        add(4'b0000, 4'b0010, 4'b0000, 0, 4'b0010, 0, 4);
        add(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2);

        reset = 1'b1;
        req8 = 4'b0;
        req4 = 4'b0;
        #1;
        chk("rst8", g8, v8, id8, t8, 4'b0, 1'b0);
        chk("rst4", g4, v4, id4, t4, 4'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i])
            for (int j = 0; j < tbl[i].n; j++) apply(tbl[i]);

        // asynchronous reset in the middle of a grant
        req4 = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst", g4, v4, id4, t4, 4'b0010, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst", g4, v4, id4, t4, 4'b0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_rst", g4, v4, id4, t4, 4'b0000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("regrant", g4, v4, id4, t4, 4'b0010, 1'b0);
        chk("idle8", g8, v8, id8, t8, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Sequential 4-requester arbiter that shares one resource (bus, datapath port) between requesters using the same 3 > 2 > 1 > 0 priority order as the combinational priority circuit. Grants are registered one-hot, held while the owner keeps requesting, and bounded by a hold-timeout. Each grant ends with a one-cycle turnaround. Optional round-robin rotation prevents starvation of low-index requesters.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one owner holds the grant; 0 = unlimited.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  request lines; req[i] high = requester i wants the resource.
- grant  out  4  one-hot grant, or 4'b0000 when no owner.
- grant_valid  out  1  high iff grant != 0.
- grant_id  out  2  index of current owner; 2'd0 when grant_valid = 0.
- timeout  out  1  one-cycle pulse: current grant revoked by MAX_HOLD.

## Operation
- All outputs are registered.
- Reset values: grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, state = IDLE, hold counter = 0, rotation pointer = 3.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - req == 0: stay in IDLE.
  - Otherwise: go to GRANT and register the one-hot grant of the winner. Hold counter = 1.
- GRANT:
  - Owner's req still high and (MAX_HOLD == 0 or counter < MAX_HOLD): stay. Counter increments, saturating at its width, which is $clog2(MAX_HOLD+1), minimum 1 bit.
  - Owner's req low: go to RELEASE. grant = 0.
  - Owner's req high and counter == MAX_HOLD (MAX_HOLD != 0): go to RELEASE. grant = 0, and timeout pulses high in the first RELEASE cycle.
  - Requests from non-owners never preempt.
- RELEASE (turnaround, grant = 0):
  - Arbitrate over req with the previous owner masked only if it timed out.
  - Masked request vector nonzero: go to GRANT with the new winner.
  - Otherwise: go to IDLE.
- Winner selection (fixed mode): highest set index of the eligible req bits.
- grant_id always encodes grant. grant never has more than one bit set.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously). No grant until at least one edge after reset deasserts.

## Timing
- Request-to-grant latency: req sampled high at edge k (state IDLE) -> grant high after edge k.
- Release latency: owner drops req before edge k -> grant low after edge k.
- Minimum gap between successive grants: exactly one cycle (RELEASE).
- Continuous request with MAX_HOLD = M: the owner holds grant for exactly M cycles, then 1 dead cycle, then rearbitration.
- Back-to-back reacquire: an owner that released voluntarily (not timed out) and still requests in RELEASE is eligible. It can win again with a one-cycle gap.
- Simultaneous release by the owner and reaching MAX_HOLD: treated as a voluntary release. timeout stays 0.
- Request withdrawn during RELEASE: not considered at that edge.

## Configuration
- ROUND_ROBIN_EN defined:
  - A 2-bit pointer p gives highest priority to index p, then p-1, p-2, p-3 (mod 4).
  - On every grant to index i, p is updated to (i-1) mod 4, so i becomes lowest priority.
  - Pointer reset value = 3, so the first arbitration matches fixed order.
- ROUND_ROBIN_EN undefined: fixed priority 3 > 2 > 1 > 0 and no pointer register. The timeout mask remains active.

## Test plan
- Reset, then req = 4'b0101 at edge 1 -> grant = 4'b0100, grant_id = 2 after edge 1. Drop req[2] -> one cycle grant = 0, then grant = 4'b0001.
- MAX_HOLD = 8, req = 4'b1000 held for 20 cycles -> grant = 4'b1000 for 8 cycles, timeout pulses once in the dead cycle, then (req[3] alone but masked) IDLE for 1 cycle, then regrant.
- Fixed mode, req = 4'b1111 constant, MAX_HOLD = 4 -> grants 3, 2 (after timeout mask), 3, 2 ... each 4 cycles with 1-cycle gaps. Requester 1 never granted.
- ROUND_ROBIN_EN, req = 4'b1111 constant, MAX_HOLD = 4 -> grant order 3, 2, 1, 0, 3, each 4 cycles with 1-cycle gaps.
- Assert reset during grant = 4'b0010 -> grant, grant_valid, grant_id, timeout all 0 before the next clock edge. With req = 4'b0010 still high, the first grant comes one edge after reset releases.
- Owner drops req on the same edge its counter hits MAX_HOLD = 4 -> grant low after that edge, timeout = 0.
